// File: rtl/time_settings.sv
// Shared time settings for the emulation time manager.
//   TIME_WIDTH    : width of emulated time (time_t is the time format,
//                   unsigned integer ticks)
//   DT_WIDTH      : width of a requested step (dt_t is the delay format,
//                   unsigned integer ticks)
//   NUM_REQ_DEFAULT : default number of event requesters
//   tm_state_t    : time manager FSM states
package time_settings;

    localparam int TIME_WIDTH      = 12;
    localparam int DT_WIDTH        = 8;
    localparam int NUM_REQ_DEFAULT = 2;

    typedef logic [TIME_WIDTH-1:0] time_t;
    typedef logic [DT_WIDTH-1:0]   dt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_ADV  = 2'd3
    } tm_state_t;

endpackage

// File: rtl/dt_min_select.sv
// Combinational step selection: clamps every requested delay to DT_MAX,
// finds the unsigned minimum and flags every requester tied at it.
//   req_dt   : in  NUM_REQ x DT_WIDTH packed delays (requester i at slice i)
//   dt_min   : out minimum clamped delay
//   tie_mask : out bit i set when requester i's clamped delay equals dt_min
module dt_min_select
    import time_settings::*;
#(
    parameter int          NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned DT_MAX  = (2**DT_WIDTH)-1
) (
    input  logic [NUM_REQ*DT_WIDTH-1:0] req_dt,
    output logic [DT_WIDTH-1:0]         dt_min,
    output logic [NUM_REQ-1:0]          tie_mask
);

    localparam logic [DT_WIDTH-1:0] DT_LIMIT = DT_WIDTH'(DT_MAX);

    logic [DT_WIDTH-1:0] dt_clamped [NUM_REQ];

    always_comb begin
        // All-ones start value is never below any clamped delay.
        dt_min   = '1;
        tie_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dt_clamped[i] = (req_dt[i*DT_WIDTH +: DT_WIDTH] > DT_LIMIT)
                          ? DT_LIMIT : req_dt[i*DT_WIDTH +: DT_WIDTH];
            if (dt_clamped[i] < dt_min) begin
                dt_min = dt_clamped[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            tie_mask[i] = (dt_clamped[i] == dt_min);
        end
    end

endmodule

// File: rtl/time_manager.sv
// Discrete-event time manager. Waits until every requester presents its
// next-event delay, advances emulated time by the smallest one and grants
// all requesters whose event falls on the new time.
//   clk_sys   : in  system emulation clock
//   rst_n     : in  asynchronous active-low reset
//   emu_run   : in  1 = keep stepping, 0 = stop after the current step
//   req_valid : in  per-requester pending delay
//   req_dt    : in  per-requester delay (requester i at slice i)
//   req_ready : out per-requester one-cycle consume pulse (ADV only)
//   time_eq   : out per-requester one-cycle event pulse (ADV only)
//   time_next : out current emulated time
//   time_ovf  : out sticky overflow flag
//   state_dbg : out current FSM state (tm_state_t encoding)
//
// Handshake: a requester holds req_valid/req_dt stable until it sees its
// req_ready pulse; the block only samples requests while in WAIT and
// consumes exactly the requesters flagged in the same-cycle req_ready.
module time_manager
    import time_settings::*;
#(
    parameter int          NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned DT_MAX  = (2**DT_WIDTH)-1
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic                        emu_run,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DT_WIDTH-1:0] req_dt,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          time_eq,
    output logic [TIME_WIDTH-1:0]       time_next,
    output logic                        time_ovf,
    output logic [1:0]                  state_dbg
);

    tm_state_t             state_q,    state_d;
    logic [DT_WIDTH-1:0]   dt_min_q,   dt_min_d;
    logic [NUM_REQ-1:0]    tie_mask_q, tie_mask_d;
    logic [TIME_WIDTH-1:0] time_q,     time_d;
    logic                  ovf_q,      ovf_d;

    logic [DT_WIDTH-1:0]   sel_dt_min;
    logic [NUM_REQ-1:0]    sel_tie_mask;
    // One extra bit so the carry out marks an advance that would wrap.
    logic [TIME_WIDTH:0]   time_sum;

    dt_min_select #(
        .NUM_REQ (NUM_REQ),
        .DT_MAX  (DT_MAX)
    ) u_dt_min_select (
        .req_dt   (req_dt),
        .dt_min   (sel_dt_min),
        .tie_mask (sel_tie_mask)
    );

    assign time_sum = {1'b0, time_q} + {{(TIME_WIDTH+1-DT_WIDTH){1'b0}}, dt_min_q};

    always_comb begin
        state_d    = state_q;
        dt_min_d   = dt_min_q;
        tie_mask_d = tie_mask_q;
        time_d     = time_q;
        ovf_d      = ovf_q;
        time_eq    = '0;
        req_ready  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (emu_run) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!emu_run)        state_d = ST_IDLE;
                else if (&req_valid) state_d = ST_CMP;
            end
            ST_CMP: begin
                dt_min_d   = sel_dt_min;
                tie_mask_d = sel_tie_mask;
                state_d    = ST_ADV;
            end
            ST_ADV: begin
                time_eq   = tie_mask_q;
                req_ready = tie_mask_q;
                // A wrapping advance freezes time but still grants.
                if (time_sum[TIME_WIDTH]) ovf_d  = 1'b1;
                else                      time_d = time_sum[TIME_WIDTH-1:0];
                state_d = emu_run ? ST_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dt_min_q   <= '0;
            tie_mask_q <= '0;
            time_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dt_min_q   <= dt_min_d;
            tie_mask_q <= tie_mask_d;
            time_q     <= time_d;
            ovf_q      <= ovf_d;
        end
    end

    assign time_next = time_q;
    assign time_ovf  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_time_manager.sv
// Bench for time_manager with two requesters and DT_MAX lowered to 200 so
// that clamping is exercised. A reference model computes each step's
// grant set and new time from the delays with plain integer arithmetic.
module tb_time_manager;
    import time_settings::*;

    localparam int NREQ     = 2;
    localparam int DTMAX    = 200;
    localparam int TIME_MAX = (2**TIME_WIDTH)-1;

    logic                     clk_sys = 1'b0;
    logic                     rst_n;
    logic                     emu_run;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DT_WIDTH-1:0] req_dt;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          time_eq;
    logic [TIME_WIDTH-1:0]    time_next;
    logic                     time_ovf;
    logic [1:0]               state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    int exp_time = 0;
    bit exp_ovf  = 1'b0;

    time_manager #(.NUM_REQ(NREQ), .DT_MAX(DTMAX)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .emu_run   (emu_run),
        .req_valid (req_valid),
        .req_dt    (req_dt),
        .req_ready (req_ready),
        .time_eq   (time_eq),
        .time_next (time_next),
        .time_ovf  (time_ovf),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    // One full step: present both delays in WAIT, wait for the grant and
    // check it against the model, then check the advanced time.
    task automatic step(input int d0, input int d1, input string name);
        int c0, c1, m, cycles;
        logic [NREQ-1:0] exp_mask;
        logic [TIME_WIDTH-1:0] old_time;
        bit got;
        c0 = (d0 > DTMAX) ? DTMAX : d0;
        c1 = (d1 > DTMAX) ? DTMAX : d1;
        m  = (c0 < c1) ? c0 : c1;
        exp_mask = {(c1 == m), (c0 == m)};
        old_time = TIME_WIDTH'(exp_time);
        if (exp_time + m > TIME_MAX) exp_ovf = 1'b1;
        else                         exp_time = exp_time + m;

        req_dt    = {d1[DT_WIDTH-1:0], d0[DT_WIDTH-1:0]};
        req_valid = 2'b11;
        cycles = 0;
        got    = 1'b0;
        while (cycles < 8 && !got) begin
            @(negedge clk_sys);
            cycles++;
            if (req_ready !== 2'b00) got = 1'b1;
        end
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s timeout: no req_ready within %0d cycles", name, cycles);
        end else begin
            tests_run++;
            if (cycles !== 2) begin
                tests_failed++;
                $display("FAIL %s latency: got %0d cycles, expected 2", name, cycles);
            end
            tests_run++;
            if (time_eq !== exp_mask) begin
                tests_failed++;
                $display("FAIL %s time_eq: got %b, expected %b", name, time_eq, exp_mask);
            end
            tests_run++;
            if (req_ready !== exp_mask) begin
                tests_failed++;
                $display("FAIL %s req_ready: got %b, expected %b", name, req_ready, exp_mask);
            end
            tests_run++;
            if (time_next !== old_time) begin
                tests_failed++;
                $display("FAIL %s time_before: got %0d, expected %0d", name, time_next, old_time);
            end
        end
        req_valid = 2'b00;
        @(negedge clk_sys);
        tests_run++;
        if (time_next !== TIME_WIDTH'(exp_time)) begin
            tests_failed++;
            $display("FAIL %s time_next: got %0d, expected %0d", name, time_next, exp_time);
        end
        tests_run++;
        if (time_ovf !== exp_ovf) begin
            tests_failed++;
            $display("FAIL %s time_ovf: got %b, expected %b", name, time_ovf, exp_ovf);
        end
        tests_run++;
        if (time_eq !== 2'b00 || req_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s pulse_width: time_eq %b req_ready %b, expected 00 00",
                     name, time_eq, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        emu_run   = 1'b0;
        req_valid = '0;
        req_dt    = '0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        tests_run++;
        if (time_next !== '0 || time_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_time: time_next %0d ovf %b, expected 0 0", time_next, time_ovf);
        end
        tests_run++;
        if (time_eq !== '0 || req_ready !== '0) begin
            tests_failed++;
            $display("FAIL reset_pulses: time_eq %b req_ready %b, expected 00 00", time_eq, req_ready);
        end
        tests_run++;
        if (state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d, expected %0d", state_dbg, ST_IDLE);
        end
        emu_run = 1'b1;
        @(negedge clk_sys);
        tests_run++;
        if (state_dbg !== ST_WAIT) begin
            tests_failed++;
            $display("FAIL run_to_wait: got %0d, expected %0d", state_dbg, ST_WAIT);
        end
    endtask

    task automatic test_basic();
        step(5, 9, "basic_5_9");
        step(4, 9, "basic_4_9");
    endtask

    task automatic test_tie();
        step(7, 7, "tie_7_7");
    endtask

    task automatic test_zero_dt();
        step(0, 3, "zero_0_3");
        step(10, 3, "zero_follow");
    endtask

    task automatic test_clamp();
        step(250, 220, "clamp_tie");
        step(255, 150, "clamp_one");
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            step($urandom_range(0, 120), $urandom_range(0, 120), "random");
        end
    endtask

    task automatic test_overflow();
        int d;
        while (exp_time < TIME_MAX - 1) begin
            d = TIME_MAX - 1 - exp_time;
            if (d > DTMAX) d = DTMAX;
            step(d, 255, "ovf_climb");
        end
        step(5, 9, "ovf_wrap");
        step(0, 1, "ovf_sticky");
    endtask

    task automatic test_stall();
        logic [TIME_WIDTH-1:0] t0;
        bit saw_grant;
        t0 = time_next;
        saw_grant = 1'b0;
        req_dt    = {8'd3, 8'd2};
        req_valid = 2'b01;
        repeat (20) begin
            @(negedge clk_sys);
            if (req_ready !== 2'b00 || time_eq !== 2'b00) saw_grant = 1'b1;
        end
        tests_run++;
        if (saw_grant) begin
            tests_failed++;
            $display("FAIL stall_grant: got grant pulse, expected none");
        end
        tests_run++;
        if (state_dbg !== ST_WAIT) begin
            tests_failed++;
            $display("FAIL stall_state: got %0d, expected %0d", state_dbg, ST_WAIT);
        end
        tests_run++;
        if (time_next !== t0) begin
            tests_failed++;
            $display("FAIL stall_time: got %0d, expected %0d", time_next, t0);
        end
        emu_run = 1'b0;
        @(negedge clk_sys);
        tests_run++;
        if (state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL stall_idle: got %0d, expected %0d", state_dbg, ST_IDLE);
        end
        req_valid = 2'b00;
        emu_run   = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_step();
        bit saw_grant;
        saw_grant = 1'b0;
        req_dt    = {8'd4, 8'd3};
        req_valid = 2'b11;
        @(posedge clk_sys);
        #1;
        tests_run++;
        if (state_dbg !== ST_CMP) begin
            tests_failed++;
            $display("FAIL mid_cmp_state: got %0d, expected %0d", state_dbg, ST_CMP);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (time_next !== '0 || time_ovf !== 1'b0 || time_eq !== '0 ||
            req_ready !== '0 || state_dbg !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL mid_reset_async: time %0d ovf %b eq %b rdy %b st %0d, expected 0 0 00 00 0",
                     time_next, time_ovf, time_eq, req_ready, state_dbg);
        end
        exp_time  = 0;
        exp_ovf   = 1'b0;
        req_valid = 2'b00;
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk_sys);
            if (req_ready !== 2'b00 || time_eq !== 2'b00) saw_grant = 1'b1;
        end
        tests_run++;
        if (saw_grant || time_next !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_after: grant %b time %0d, expected 0 0", saw_grant, time_next);
        end
        step(3, 4, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_zero_dt();
        test_clamp();
        test_random();
        test_overflow();
        test_stall();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/time_manager.md
TIME_MANAGER -- requirements
Module: time_manager

Interface
REQ-001 Parameter: NUM_REQ, default 2, number of event requesters (TX/RX/filter sources), range 1..8.
REQ-002 Parameter: DT_MAX, default (2**DT_WIDTH)-1, largest legal step; larger requests are clamped to it.
REQ-003 Port: clk_sys  input  1  system emulation clock.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: emu_run  input  1  1 = advance time; 0 = freeze after the current step.
REQ-006 Port: req_valid  input  NUM_REQ  requester i has a pending next-event delay.
REQ-007 Port: req_dt  input  NUM_REQ x DT_WIDTH  unsigned delay to requester i's next event.
REQ-008 Port: req_ready  output  NUM_REQ  one-cycle pulse; requester i's request is consumed.
REQ-009 Port: time_eq  output  NUM_REQ  one-cycle pulse; emulated time equals requester i's event.
REQ-010 Port: time_next  output  TIME_WIDTH  current emulated time (TIME_FORMAT), feeds filter time history.
REQ-011 Port: time_ovf  output  1  sticky flag; time advance would wrap.

Function
REQ-012 States: IDLE, WAIT, CMP, ADV; reset state IDLE.
REQ-013 IDLE -> WAIT when emu_run=1; otherwise remain.
REQ-014 WAIT -> CMP when every req_valid bit is 1; otherwise remain; WAIT -> IDLE if emu_run=0.
REQ-015 CMP: register dt_min = minimum of clamped req_dt, and tie mask = bits whose clamped dt equals dt_min; always -> ADV next cycle.
REQ-016 ADV: time_next <= time_next + dt_min; time_eq and req_ready pulse high for the tie-mask bits only, same cycle as the update; -> WAIT if emu_run=1 else IDLE.
REQ-017 Non-winning requesters keep their valid; their req_dt is NOT decremented by the block (requesters re-issue absolute-relative delay themselves after observing time_next).
REQ-018 Latency: all valid sampled in WAIT at cycle n -> time_eq/req_ready high at cycle n+2, time_next updated at n+2 (visible n+2 registered edge).
REQ-019 Requester shall hold req_valid/req_dt stable until its req_ready; block only samples in WAIT.
REQ-020 Ties: all equal-minimum requesters are granted in the same ADV cycle; no priority ordering.
REQ-021 dt_min=0: ADV pulses grants, time_next unchanged.
REQ-022 Overflow: if time_next + dt_min exceeds 2**TIME_WIDTH-1, time_next holds, time_ovf sets and stays 1 until reset, grants still issue.
REQ-023 Minimum search is unsigned, full DT_WIDTH; sum computed in TIME_WIDTH+1 bits for overflow detection.
REQ-024 Outside ADV, time_eq and req_ready are 0.

Reset
REQ-025 rst_n low asynchronously forces state IDLE, time_next=0, time_eq=0, req_ready=0, time_ovf=0, dt_min=0, tie mask=0.
REQ-026 Reset asserted mid-CMP/ADV aborts the step; no grant pulse and no time update after release.
REQ-027 First step after rst_n release needs at least one WAIT cycle.

Structure
REQ-028 TIME_WIDTH, DT_WIDTH, TIME_FORMAT, DT_FORMAT come from the shared time_settings package; NUM_REQ default and state enum type go in time_settings.
REQ-029 One sub-module dt_min_select: combinational clamp + unsigned minimum + tie-mask over NUM_REQ inputs; registering done in time_manager.

Verification
REQ-030 NUM_REQ=2, run=1, dt={5,9} valid -> cycle+2: time_eq=01, time_next 0->5; re-request dt={4,... held 9} -> time_eq=01? no: dt {4,9} -> grant 01, time_next=9.
REQ-031 Tie: dt={7,7} -> time_eq=11 in one pulse, time_next+=7.
REQ-032 dt={0,3} -> time_eq=01, time_next unchanged; following step grants req1 with +3.
REQ-033 time_next=2**TIME_WIDTH-2, dt_min=5 -> time_ovf=1, time_next holds, grants issue.
REQ-034 Only req_valid=01 held for 20 cycles -> no grants, state WAIT, time_next constant; emu_run=0 -> IDLE.
REQ-035 rst_n pulsed low during CMP -> outputs zero immediately, no grant after release, time_next=0.
